mem_stage: RTL and testbench

- Memory-access stage directly downstream of the ALU/execute stage.
- Consumes the execute result (address or pass-through value) plus store data and memory-op code.
- Performs aligned loads and stores over a req/ack data bus, and detects misalignment and bus timeout.
- Hands a register-writeback record to the WB stage over a valid/ready handshake.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_align.sv | 60 ++++++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory-op encodings, FSM states and op decode helpers
package mem_stage_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LW   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LHU  = 4'd3,
      MEM_LB   = 4'd4,
      MEM_LBU  = 4'd5,
      MEM_SW   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SB   = 4'd8
   } mem_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } size_e;

   // Reserved codes decode to SZ_NONE and therefore behave as MEM_NONE.
   function automatic size_e op_size(input logic [3:0] op);
      case (op)
         MEM_LW, MEM_SW:          return SZ_WORD;
         MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
         MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
         default:                 return SZ_NONE;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
   endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - little-endian byte-lane logic for both bus directions
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [3:0]  i_st_op,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   input  logic [3:0]  i_ld_op,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte enables are produced for loads as well, so the same path serves reads.
   always_comb begin
      o_be         = 4'b0000;
      o_wdata      = i_st_data;
      o_misaligned = 1'b0;
      case (op_size(i_st_op))
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_st_off;
            o_wdata = {4{i_st_data[7:0]}};
         end
         SZ_HALF: begin
            o_be         = 4'b0011 << {i_st_off[1], 1'b0};
            o_wdata      = {2{i_st_data[15:0]}};
            o_misaligned = i_st_off[0];
         end
         SZ_WORD: begin
            o_be         = 4'b1111;
            o_misaligned = |i_st_off;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (i_ld_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_ld_op)
         MEM_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
         MEM_LBU: o_ld_data = {24'd0, w_byte};
         MEM_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
         MEM_LHU: o_ld_data = {16'd0, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: aligned loads/stores over req/ack bus
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_out,
   input  logic [31:0] store_data,
   input  logic [3:0]  mem_op,
   input  logic [4:0]  rd,
   input  logic        reg_we,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        exc_bus,
   output logic [31:0] bad_vaddr
);

   state_e      r_state, w_next_state;
   logic [3:0]  r_op;
   logic [31:0] r_addr;
   logic [4:0]  r_rd;
   logic        r_we;
   logic [31:0] r_timer;

   logic        r_out_valid, r_out_we;
   logic [31:0] r_out_data;
   logic [4:0]  r_out_rd;
   logic        r_bus_req, r_bus_we;
   logic [31:0] r_bus_addr, r_bus_wdata;
   logic [3:0]  r_bus_be;
   logic        r_exc_adel, r_exc_ades, r_exc_bus;
   logic [31:0] r_bad_vaddr;

   logic        w_free, w_accept, w_is_mem, w_is_store, w_misaligned;
   logic        w_ack, w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_ld_data;

   assign w_free     = !r_out_valid || out_ready;
   assign in_ready   = (r_state == ST_IDLE) && w_free;
   assign w_accept   = in_valid && in_ready;
   assign w_is_mem   = (op_size(mem_op) != SZ_NONE);
   assign w_is_store = op_is_store(mem_op);
   assign w_ack      = (r_state == ST_BUS) && bus_ack;
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == ST_BUS) && !bus_ack &&
                       (r_timer + 32'd1 == 32'(TIMEOUT_CYCLES));

   mem_align u_align (
      .i_st_op      (mem_op),
      .i_st_off     (alu_out[1:0]),
      .i_st_data    (store_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_misaligned),
      .i_ld_op      (r_op),
      .i_ld_off     (r_addr[1:0]),
      .i_rdata      (bus_rdata),
      .o_ld_data    (w_ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept && w_is_mem && !w_misaligned) w_next_state = ST_BUS;
         ST_BUS:  if (w_ack || w_timeout)                     w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op        <= 4'd0;
         r_addr      <= 32'd0;
         r_rd        <= 5'd0;
         r_we        <= 1'b0;
         r_timer     <= 32'd0;
         r_out_valid <= 1'b0;
         r_out_we    <= 1'b0;
         r_out_data  <= 32'd0;
         r_out_rd    <= 5'd0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_be    <= 4'd0;
         r_bus_wdata <= 32'd0;
         r_exc_adel  <= 1'b0;
         r_exc_ades  <= 1'b0;
         r_exc_bus   <= 1'b0;
         r_bad_vaddr <= 32'd0;
      end else begin
         r_exc_adel <= 1'b0;
         r_exc_ades <= 1'b0;
         r_exc_bus  <= 1'b0;
         if (r_out_valid && out_ready) r_out_valid <= 1'b0;

         if (w_accept) begin
            r_op    <= mem_op;
            r_addr  <= alu_out;
            r_rd    <= rd;
            r_we    <= reg_we;
            r_timer <= 32'd0;
            if (!w_is_mem) begin
               r_out_valid <= 1'b1;
               r_out_data  <= alu_out;
               r_out_rd    <= rd;
               r_out_we    <= reg_we;
            end else if (w_misaligned) begin
               r_out_valid <= 1'b1;
               r_out_data  <= alu_out;
               r_out_rd    <= rd;
               r_out_we    <= 1'b0;
               r_exc_adel  <= !w_is_store;
               r_exc_ades  <= w_is_store;
               r_bad_vaddr <= alu_out;
            end else begin
               r_bus_req   <= 1'b1;
               r_bus_we    <= w_is_store;
               r_bus_addr  <= {alu_out[31:2], 2'b00};
               r_bus_be    <= w_be;
               r_bus_wdata <= w_wdata;
            end
         end else if (w_ack) begin
            r_bus_req   <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_rd    <= r_rd;
            r_out_we    <= !op_is_store(r_op) && r_we;
            r_out_data  <= op_is_store(r_op) ? 32'd0 : w_ld_data;
         end else if (w_timeout) begin
            r_bus_req   <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= 32'd0;
            r_out_rd    <= r_rd;
            r_out_we    <= 1'b0;
            r_exc_bus   <= 1'b1;
            r_bad_vaddr <= r_addr;
            r_timer     <= 32'd0;
         end else if (r_state == ST_BUS) begin
            r_timer <= r_timer + 32'd1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_rd    = r_out_rd;
   assign out_we    = r_out_we;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_be    = r_bus_be;
   assign bus_wdata = r_bus_wdata;
   assign exc_adel  = r_exc_adel;
   assign exc_ades  = r_exc_ades;
   assign exc_bus   = r_exc_bus;
   assign bad_vaddr = r_bad_vaddr;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with writeback scoreboard
module tb_mem_stage;

   localparam logic [3:0] OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                          OP_LB = 4'd4, OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7,
                          OP_SB = 4'd8;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [31:0] alu_out, store_data;
   logic [3:0]  mem_op;
   logic [4:0]  rd;
   logic        reg_we;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        exc_adel, exc_ades, exc_bus;
   logic [31:0] bad_vaddr;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        chk_data;
   } wb_t;

   wb_t exp_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .store_data(store_data), .mem_op(mem_op), .rd(rd), .reg_we(reg_we),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus), .bad_vaddr(bad_vaddr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] r, input logic we, input logic cd);
      wb_t e;
      e.data = d; e.rd = r; e.we = we; e.chk_data = cd;
      exp_q.push_back(e);
   endtask

   // Returns one ns after the accepting edge.
   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] r, input logic we);
      in_valid = 1'b1; mem_op = op; alu_out = a; store_data = sd; rd = r; reg_we = we;
      for (int i = 0; i < 20 && !in_ready; i++) cyc();
      chk("accept_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rdata,
                          input logic [31:0] exp_d, input logic [3:0] exp_be, input logic [4:0] r);
      push(exp_d, r, 1'b1, 1'b1);
      drive(op, a, 32'd0, r, 1'b1);
      chk("ld_req", {31'd0, bus_req}, 32'd1);
      chk("ld_we", {31'd0, bus_we}, 32'd0);
      chk("ld_addr", bus_addr, {a[31:2], 2'b00});
      chk("ld_be", {28'd0, bus_be}, {28'd0, exp_be});
      chk("ld_early_valid", {31'd0, out_valid}, 32'd0);
      bus_ack = 1'b1; bus_rdata = rdata;
      cyc();
      bus_ack = 1'b0;
      chk("ld_valid_t2", {31'd0, out_valid}, 32'd1);
      chk("ld_req_drop", {31'd0, bus_req}, 32'd0);
   endtask

   task automatic do_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] exp_wd, input logic [3:0] exp_be, input logic [4:0] r);
      push(32'd0, r, 1'b0, 1'b0);
      drive(op, a, sd, r, 1'b1);
      chk("st_req", {31'd0, bus_req}, 32'd1);
      chk("st_we", {31'd0, bus_we}, 32'd1);
      chk("st_addr", bus_addr, {a[31:2], 2'b00});
      chk("st_be", {28'd0, bus_be}, {28'd0, exp_be});
      chk("st_wdata", bus_wdata, exp_wd);
      cyc();
      chk("st_hold_req", {31'd0, bus_req}, 32'd1);
      chk("st_hold_wdata", bus_wdata, exp_wd);
      chk("st_hold_be", {28'd0, bus_be}, {28'd0, exp_be});
      bus_ack = 1'b1;
      cyc();
      bus_ack = 1'b0;
      chk("st_valid", {31'd0, out_valid}, 32'd1);
      chk("st_req_drop", {31'd0, bus_req}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL wb_unexpected: observed record rd=%0d data=0x%08h expected none", out_rd, out_data);
         end
         if (exp_q.size() != 0) begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rd", {27'd0, out_rd}, {27'd0, e.rd});
            chk("wb_we", {31'd0, out_we}, {31'd0, e.we});
            if (e.chk_data) chk("wb_data", out_data, e.data);
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; alu_out = 32'd0; store_data = 32'd0; mem_op = 4'd0;
      rd = 5'd0; reg_we = 1'b0; out_ready = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
      cyc(); cyc();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_exc", {29'd0, exc_adel, exc_ades, exc_bus}, 32'd0);
      chk("rst_bad_vaddr", bad_vaddr, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Pass-through op, latency 1
      push(32'h1234_5678, 5'd3, 1'b1, 1'b1);
      drive(OP_NONE, 32'h1234_5678, 32'd0, 5'd3, 1'b1);
      chk("none_valid", {31'd0, out_valid}, 32'd1);
      chk("none_data", out_data, 32'h1234_5678);
      chk("none_no_req", {31'd0, bus_req}, 32'd0);
      cyc();

      // Reserved code behaves as pass-through
      push(32'h0000_0055, 5'd6, 1'b1, 1'b1);
      drive(4'hF, 32'h0000_0055, 32'd0, 5'd6, 1'b1);
      chk("rsvd_no_req", {31'd0, bus_req}, 32'd0);
      chk("rsvd_valid", {31'd0, out_valid}, 32'd1);
      cyc();

      do_load(OP_LB,  32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80, 4'b1000, 5'd5);
      do_load(OP_LBU, 32'h0000_0102, 32'h80FF_0000, 32'h0000_00FF, 4'b0100, 5'd10);
      do_load(OP_LH,  32'h0000_0802, 32'h8001_1234, 32'hFFFF_8001, 4'b1100, 5'd11);
      do_load(OP_LHU, 32'h0000_0800, 32'h8001_1234, 32'h0000_1234, 4'b0011, 5'd12);
      do_load(OP_LW,  32'h0000_0904, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 5'd13);

      do_store(OP_SH, 32'h0000_0202, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, 5'd7);
      do_store(OP_SB, 32'h0000_0701, 32'h1234_5678, 32'h7878_7878, 4'b0010, 5'd8);
      do_store(OP_SW, 32'h0000_0A00, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 5'd14);

      // Misaligned load and store
      push(32'd0, 5'd9, 1'b0, 1'b0);
      drive(OP_LW, 32'h0000_0301, 32'd0, 5'd9, 1'b1);
      chk("adel_pulse", {31'd0, exc_adel}, 32'd1);
      chk("adel_ades", {31'd0, exc_ades}, 32'd0);
      chk("adel_vaddr", bad_vaddr, 32'h0000_0301);
      chk("adel_no_req", {31'd0, bus_req}, 32'd0);
      chk("adel_valid", {31'd0, out_valid}, 32'd1);
      cyc();
      chk("adel_pulse_end", {31'd0, exc_adel}, 32'd0);
      chk("adel_no_req2", {31'd0, bus_req}, 32'd0);
      push(32'd0, 5'd15, 1'b0, 1'b0);
      drive(OP_SH, 32'h0000_0403, 32'h1111_2222, 5'd15, 1'b1);
      chk("ades_pulse", {31'd0, exc_ades}, 32'd1);
      chk("ades_vaddr", bad_vaddr, 32'h0000_0403);
      chk("ades_no_req", {31'd0, bus_req}, 32'd0);
      cyc();

      // Bus timeout after 4 request cycles
      push(32'd0, 5'd4, 1'b0, 1'b0);
      drive(OP_LW, 32'h0000_0500, 32'd0, 5'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("to_req_high", {31'd0, bus_req}, 32'd1);
         chk("to_no_exc", {31'd0, exc_bus}, 32'd0);
         cyc();
      end
      chk("to_req_drop", {31'd0, bus_req}, 32'd0);
      chk("to_exc_bus", {31'd0, exc_bus}, 32'd1);
      chk("to_vaddr", bad_vaddr, 32'h0000_0500);
      chk("to_in_ready", {31'd0, in_ready}, 32'd1);
      chk("to_valid", {31'd0, out_valid}, 32'd1);
      cyc();
      chk("to_exc_end", {31'd0, exc_bus}, 32'd0);
      cyc();

      // Backpressure: first record held, second accepted when out_ready rises
      out_ready = 1'b0;
      push(32'h0000_000A, 5'd1, 1'b1, 1'b1);
      drive(OP_NONE, 32'h0000_000A, 32'd0, 5'd1, 1'b1);
      push(32'h0000_000B, 5'd2, 1'b1, 1'b1);
      in_valid = 1'b1; mem_op = OP_NONE; alu_out = 32'h0000_000B; rd = 5'd2; reg_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_data", out_data, 32'h0000_000A);
         chk("bp_hold_rd", {27'd0, out_rd}, 32'd1);
         cyc();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_second_data", out_data, 32'h0000_000B);
      cyc();

      // Asynchronous reset in the middle of a bus cycle
      drive(OP_LW, 32'h0000_0600, 32'd0, 5'd20, 1'b1);
      chk("rst_mid_req", {31'd0, bus_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_req", {31'd0, bus_req}, 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      chk("rst_after_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_after_ready", {31'd0, in_ready}, 32'd1);
      cyc(); cyc();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
